// File: rtl/vend_pkg.sv
// Shared types and constants for the vending sequencer.
// Holds the controller state encoding, default coin values and price,
// the credit datapath width and a helper that narrows integer
// parameters to credit width.
package vend_pkg;

    localparam int CREDIT_W = 7;
    localparam int TICK_W   = 8;

    localparam int unsigned PRICE_DEF        = 50;
    localparam int unsigned VAL_A_DEF        = 5;
    localparam int unsigned VAL_B_DEF        = 10;
    localparam int unsigned VAL_C_DEF        = 25;
    localparam int unsigned DISP_TICKS_DEF   = 3;
    localparam int unsigned IDLE_TIMEOUT_DEF = 10;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COLLECT  = 2'd1,
        DISPENSE = 2'd2,
        RETURN   = 2'd3
    } state_t;

    // Narrow an integer parameter to the credit datapath width.
    function automatic logic [CREDIT_W-1:0] to_credit(input int unsigned v);
        return v[CREDIT_W-1:0];
    endfunction

endpackage

// File: rtl/vend_sequencer_coin_arbiter.sv
// Coin pending store and fixed-priority arbiter.
// Each coin type keeps one pending bit; at most one coin is granted per
// cycle (A > B > C) and only while enabled. A pulse that lands on a
// pending, ungranted bit is lost and reported on reject one cycle later.
// Ports:
//   clk, reset          clock, async active-low reset
//   enable              grants allowed this cycle
//   coin_a/b/c          one-cycle coin pulses
//   grant_valid         a coin is granted this cycle
//   grant_value         credit value of the granted coin
//   pend_any            at least one coin is pending
//   reject              one-cycle pulse, a coin pulse was lost
module coin_arbiter
    import vend_pkg::*;
#(
    parameter int unsigned VAL_A = VAL_A_DEF,
    parameter int unsigned VAL_B = VAL_B_DEF,
    parameter int unsigned VAL_C = VAL_C_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                coin_a,
    input  logic                coin_b,
    input  logic                coin_c,
    output logic                grant_valid,
    output logic [CREDIT_W-1:0] grant_value,
    output logic                pend_any,
    output logic                reject
);

    localparam logic [CREDIT_W-1:0] VAL_A_C = to_credit(VAL_A);
    localparam logic [CREDIT_W-1:0] VAL_B_C = to_credit(VAL_B);
    localparam logic [CREDIT_W-1:0] VAL_C_C = to_credit(VAL_C);

    // bit 0 = coin A, bit 1 = coin B, bit 2 = coin C
    logic [2:0] pend_r;
    logic [2:0] pulse_s;
    logic [2:0] grant_s;
    logic       reject_r;

    assign pulse_s = {coin_c, coin_b, coin_a};

    // Fixed-priority one-hot grant from the pending bits.
    always_comb begin
        grant_s = 3'b000;
        if (enable) begin
            if (pend_r[0]) begin
                grant_s = 3'b001;
            end else if (pend_r[1]) begin
                grant_s = 3'b010;
            end else if (pend_r[2]) begin
                grant_s = 3'b100;
            end else begin
                grant_s = 3'b000;
            end
        end else begin
            grant_s = 3'b000;
        end
    end

    // Credit value of the granted coin.
    always_comb begin
        grant_value = {CREDIT_W{1'b0}};
        case (grant_s)
            3'b001:  grant_value = VAL_A_C;
            3'b010:  grant_value = VAL_B_C;
            3'b100:  grant_value = VAL_C_C;
            default: grant_value = {CREDIT_W{1'b0}};
        endcase
    end

    // Pending bits and lost-pulse flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_r   <= 3'b000;
            reject_r <= 1'b0;
        end else begin
            pend_r   <= (pend_r & ~grant_s) | pulse_s;
            reject_r <= |(pulse_s & pend_r & ~grant_s);
        end
    end

    assign grant_valid = |grant_s;
    assign pend_any    = |pend_r;
    assign reject      = reject_r;

endmodule

// File: rtl/vend_sequencer.sv
// Vending controller: accumulates arbitrated coin credit, runs a timed
// water dispense once the price is reached, and returns change or a
// refund (user stop or inactivity timeout).
// Ports:
//   clk, reset          clock, async active-low reset
//   tick                1 Hz time-base pulse
//   coin_a/b/c, stop    one-cycle input pulses
//   total               current credit (binary)
//   water               dispense valve
//   change_due          change/refund amount, valid with change_valid
//   change_valid        one-cycle change/refund pulse
//   reject              one-cycle pulse, a coin pulse was lost
//   busy                high while dispensing or returning change
module vend_sequencer
    import vend_pkg::*;
#(
    parameter int unsigned PRICE        = PRICE_DEF,
    parameter int unsigned VAL_A        = VAL_A_DEF,
    parameter int unsigned VAL_B        = VAL_B_DEF,
    parameter int unsigned VAL_C        = VAL_C_DEF,
    parameter int unsigned DISP_TICKS   = DISP_TICKS_DEF,
    parameter int unsigned IDLE_TIMEOUT = IDLE_TIMEOUT_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic                coin_a,
    input  logic                coin_b,
    input  logic                coin_c,
    input  logic                stop,
    output logic [CREDIT_W-1:0] total,
    output logic                water,
    output logic [CREDIT_W-1:0] change_due,
    output logic                change_valid,
    output logic                reject,
    output logic                busy
);

    localparam logic [CREDIT_W-1:0] PRICE_C   = to_credit(PRICE);
    localparam logic [TICK_W-1:0]   TIMEOUT_C = TICK_W'(IDLE_TIMEOUT);
    localparam logic [TICK_W-1:0]   DISP_C    = TICK_W'(DISP_TICKS);

    state_t              state_r, state_nx_s;
    logic [CREDIT_W-1:0] credit_r, credit_nx_s;
    logic [TICK_W-1:0]   tick_cnt_r, tick_nx_s;
    logic                stop_pend_r, stop_nx_s;
    logic [CREDIT_W-1:0] refund_s;
    logic [CREDIT_W-1:0] sum_s;
    logic                water_r, busy_r, change_valid_r;
    logic [CREDIT_W-1:0] change_due_r;

    logic                arb_enable_s;
    logic                grant_valid_s;
    logic [CREDIT_W-1:0] grant_value_s;
    logic                pend_any_s;

    assign arb_enable_s = (state_r == IDLE) || (state_r == COLLECT);

    coin_arbiter #(
        .VAL_A (VAL_A),
        .VAL_B (VAL_B),
        .VAL_C (VAL_C)
    ) u_arbiter (
        .clk         (clk),
        .reset       (reset),
        .enable      (arb_enable_s),
        .coin_a      (coin_a),
        .coin_b      (coin_b),
        .coin_c      (coin_c),
        .grant_valid (grant_valid_s),
        .grant_value (grant_value_s),
        .pend_any    (pend_any_s),
        .reject      (reject)
    );

    // Grants only happen below the price, so the sum never overflows.
    assign sum_s = credit_r + grant_value_s;

    // Next-state, credit, tick-counter and stop-latch logic.
    always_comb begin
        state_nx_s  = state_r;
        credit_nx_s = credit_r;
        tick_nx_s   = tick_cnt_r;
        stop_nx_s   = 1'b0;
        refund_s    = {CREDIT_W{1'b0}};
        case (state_r)
            IDLE: begin
                tick_nx_s = 8'd0;
                if (grant_valid_s) begin
                    credit_nx_s = sum_s;
                    if (sum_s >= PRICE_C) begin
                        state_nx_s = DISPENSE;
                    end else begin
                        state_nx_s = COLLECT;
                    end
                end else begin
                    state_nx_s = IDLE;
                end
            end
            COLLECT: begin
                // Coins outrank stop and timeout so a refund covers
                // every coin latched before it.
                if (grant_valid_s) begin
                    credit_nx_s = sum_s;
                    tick_nx_s   = 8'd0;
                    if (sum_s >= PRICE_C) begin
                        state_nx_s = DISPENSE;
                    end else begin
                        state_nx_s = COLLECT;
                        stop_nx_s  = stop_pend_r | stop;
                    end
                end else if (stop_pend_r && !pend_any_s) begin
                    refund_s   = credit_r;
                    tick_nx_s  = 8'd0;
                    state_nx_s = RETURN;
                end else if (tick_cnt_r == TIMEOUT_C) begin
                    refund_s   = credit_r;
                    tick_nx_s  = 8'd0;
                    state_nx_s = RETURN;
                end else begin
                    stop_nx_s = stop_pend_r | stop;
                    if (tick) begin
                        tick_nx_s = tick_cnt_r + 8'd1;
                    end else begin
                        tick_nx_s = tick_cnt_r;
                    end
                end
            end
            DISPENSE: begin
                if (tick_cnt_r == DISP_C) begin
                    tick_nx_s = 8'd0;
                    if (credit_r > PRICE_C) begin
                        refund_s   = credit_r - PRICE_C;
                        state_nx_s = RETURN;
                    end else begin
                        credit_nx_s = {CREDIT_W{1'b0}};
                        state_nx_s  = IDLE;
                    end
                end else begin
                    if (tick) begin
                        tick_nx_s = tick_cnt_r + 8'd1;
                    end else begin
                        tick_nx_s = tick_cnt_r;
                    end
                end
            end
            RETURN: begin
                credit_nx_s = {CREDIT_W{1'b0}};
                tick_nx_s   = 8'd0;
                state_nx_s  = IDLE;
            end
            default: begin
                credit_nx_s = {CREDIT_W{1'b0}};
                tick_nx_s   = 8'd0;
                state_nx_s  = IDLE;
            end
        endcase
    end

    // State, credit and registered outputs; outputs follow the next state
    // so they line up with the state they describe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r        <= IDLE;
            credit_r       <= {CREDIT_W{1'b0}};
            tick_cnt_r     <= 8'd0;
            stop_pend_r    <= 1'b0;
            water_r        <= 1'b0;
            busy_r         <= 1'b0;
            change_valid_r <= 1'b0;
            change_due_r   <= {CREDIT_W{1'b0}};
        end else begin
            state_r        <= state_nx_s;
            credit_r       <= credit_nx_s;
            tick_cnt_r     <= tick_nx_s;
            stop_pend_r    <= stop_nx_s;
            water_r        <= (state_nx_s == DISPENSE);
            busy_r         <= (state_nx_s == DISPENSE) || (state_nx_s == RETURN);
            change_valid_r <= (state_nx_s == RETURN);
            change_due_r   <= refund_s;
        end
    end

    assign total        = credit_r;
    assign water        = water_r;
    assign busy         = busy_r;
    assign change_valid = change_valid_r;
    assign change_due   = change_due_r;

endmodule

// File: tb/tb_vend_sequencer.sv
// Testbench for vend_sequencer: directed scenarios plus random coin
// sessions, with expected credit/change/dispense/reject events queued
// by a purchase-level model and compared by an output monitor.
module tb_vend_sequencer;
    import vend_pkg::*;

    localparam int PRICE   = 50;
    localparam int DISP_T  = 3;
    localparam int TIMEOUT = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic       coin_a = 1'b0, coin_b = 1'b0, coin_c = 1'b0, stop = 1'b0;
    logic [6:0] total, change_due;
    logic       water, change_valid, reject, busy;

    int checks = 0;
    int errors = 0;
    int vals [3] = '{5, 10, 25};
    int m_credit = 0;
    int exp_total_q[$];
    int exp_change_q[$];
    int exp_disp_q[$];
    int exp_reject_q[$];
    bit in_rst = 1'b1;
    int ticks_seen;
    bit done;
    int ct, r;

    vend_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .tick         (tick),
        .coin_a       (coin_a),
        .coin_b       (coin_b),
        .coin_c       (coin_c),
        .stop         (stop),
        .total        (total),
        .water        (water),
        .change_due   (change_due),
        .change_valid (change_valid),
        .reject       (reject),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // 1 Hz stand-in: one-cycle tick every 5 clocks, changed off the edges.
    initial begin
        forever begin
            repeat (4) @(posedge clk);
            #2 tick = 1'b1;
            @(posedge clk);
            #2 tick = 1'b0;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input int act);
        checks++;
        errors++;
        $display("FAIL %s actual=%0d expected=none", name, act);
    endtask

    task automatic pulse(input bit a, input bit b, input bit c, input bit s);
        @(negedge clk);
        coin_a = a; coin_b = b; coin_c = c; stop = s;
        @(negedge clk);
        coin_a = 1'b0; coin_b = 1'b0; coin_c = 1'b0; stop = 1'b0;
    endtask

    // Purchase-level model: each accepted coin raises credit; reaching the
    // price dispenses, returns any excess and clears credit.
    task automatic model_coin(input int v);
        m_credit += v;
        exp_total_q.push_back(m_credit);
        if (m_credit >= PRICE) begin
            exp_disp_q.push_back(1);
            if (m_credit > PRICE) exp_change_q.push_back(m_credit - PRICE);
            exp_total_q.push_back(0);
            m_credit = 0;
        end
    endtask

    task automatic model_refund();
        exp_change_q.push_back(m_credit);
        exp_total_q.push_back(0);
        m_credit = 0;
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (total == 7'd0 && !busy && !water) ok = 1'b1;
        end
        check(name, int'(ok), 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_water(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (water) ok = 1'b1;
        end
        check(name, int'(ok), 1);
    endtask

    // Output monitor: pops expected events whenever the DUT presents one.
    initial begin
        int prev_total = 0;
        bit prev_water = 1'b0;
        int dticks = 0;
        int e;
        forever begin
            @(negedge clk);
            if (in_rst) begin
                prev_total = int'(total);
                prev_water = water;
                dticks = 0;
            end else begin
                if (int'(total) != prev_total) begin
                    if (exp_total_q.size() == 0) unexpected("total_change", int'(total));
                    else begin
                        e = exp_total_q.pop_front();
                        check("total", int'(total), e);
                    end
                end
                if (change_valid) begin
                    check("busy_in_return", int'(busy), 1);
                    if (exp_change_q.size() == 0) unexpected("change_valid", int'(change_due));
                    else begin
                        e = exp_change_q.pop_front();
                        check("change_due", int'(change_due), e);
                    end
                end
                if (water && tick) dticks++;
                if (prev_water && !water) begin
                    if (exp_disp_q.size() == 0) unexpected("water_episode", dticks);
                    else begin
                        e = exp_disp_q.pop_front();
                        check("dispense_ticks", dticks, DISP_T);
                    end
                    dticks = 0;
                end
                if (reject) begin
                    if (exp_reject_q.size() == 0) unexpected("reject", 1);
                    else e = exp_reject_q.pop_front();
                    if (exp_reject_q.size() >= 0) checks++;
                end
                prev_total = int'(total);
                prev_water = water;
            end
        end
    end

    initial begin
        // Reset state
        #12;
        check("rst_total", int'(total), 0);
        check("rst_water", int'(water), 0);
        check("rst_change_valid", int'(change_valid), 0);
        check("rst_change_due", int'(change_due), 0);
        check("rst_reject", int'(reject), 0);
        check("rst_busy", int'(busy), 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 in_rst = 1'b0;
        repeat (2) @(negedge clk);

        // T1: two C coins 20 cycles apart, exact purchase, no change
        pulse(0, 0, 1, 0);
        model_coin(25);
        check("t1_latency_0", int'(total), 0);
        @(negedge clk);
        check("t1_latency_1", int'(total), 25);
        repeat (18) @(negedge clk);
        pulse(0, 0, 1, 0);
        model_coin(25);
        wait_idle("t1_idle");

        // T2: B, C, C -> 60, change 10
        pulse(0, 1, 0, 0); model_coin(10);
        repeat (3) @(negedge clk);
        pulse(0, 0, 1, 0); model_coin(25);
        repeat (3) @(negedge clk);
        pulse(0, 0, 1, 0); model_coin(25);
        wait_idle("t2_idle");

        // T3: A, B, C together: granted A then B then C on consecutive cycles
        pulse(1, 1, 1, 0);
        model_coin(5); model_coin(10); model_coin(25);
        check("t3_cyc0", int'(total), 0);
        @(negedge clk); check("t3_cyc1", int'(total), 5);
        @(negedge clk); check("t3_cyc2", int'(total), 15);
        @(negedge clk); check("t3_cyc3", int'(total), 40);
        pulse(0, 0, 0, 1); model_refund();
        wait_idle("t3_idle");

        // T4: C then stop -> refund 25; variant stop with A -> refund 30
        pulse(0, 0, 1, 0); model_coin(25);
        repeat (3) @(negedge clk);
        pulse(0, 0, 0, 1); model_refund();
        wait_idle("t4_idle");
        pulse(0, 0, 1, 0); model_coin(25);
        repeat (3) @(negedge clk);
        pulse(1, 0, 0, 1); model_coin(5); model_refund();
        wait_idle("t4v_idle");

        // T5: two C pulses during dispense: one held, one rejected
        pulse(0, 0, 1, 0); model_coin(25);
        repeat (2) @(negedge clk);
        pulse(0, 0, 1, 0); model_coin(25);
        wait_water("t5_water");
        pulse(0, 0, 1, 0);
        exp_reject_q.push_back(1);
        pulse(0, 0, 1, 0);
        model_coin(25);
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (total == 7'd25 && !busy) done = 1'b1;
        end
        check("t5_held_coin", int'(done), 1);
        pulse(0, 0, 0, 1); model_refund();
        wait_idle("t5_idle");

        // T6a: inactivity timeout after exactly TIMEOUT ticks
        pulse(1, 0, 0, 0); model_coin(5); model_refund();
        @(negedge clk);
        ticks_seen = 0;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            if (change_valid) done = 1'b1;
            else begin
                if (tick) ticks_seen++;
                @(negedge clk);
            end
        end
        check("t6_timeout_seen", int'(done), 1);
        check("t6_timeout_ticks", ticks_seen, TIMEOUT);
        wait_idle("t6_idle");

        // Random sessions
        for (int s = 0; s < 25; s++) begin
            if ($urandom_range(0, 7) == 0) begin
                pulse(0, 0, 0, 1);   // stop outside COLLECT is ignored
                repeat (2) @(negedge clk);
            end
            for (int n = 0; n < 20; n++) begin
                ct = int'($urandom_range(0, 2));
                pulse(ct == 0, ct == 1, ct == 2, 0);
                model_coin(vals[ct]);
                if (m_credit == 0) break;
                repeat ($urandom_range(1, 12)) @(negedge clk);
                r = int'($urandom_range(0, 7));
                if (r == 0) begin
                    pulse(0, 0, 0, 1);
                    model_refund();
                    break;
                end else if (r == 1) begin
                    model_refund();   // left to time out
                    break;
                end
            end
            wait_idle("rand_idle");
        end

        // T6b: reset mid-dispense
        pulse(0, 0, 1, 0); model_coin(25);
        repeat (2) @(negedge clk);
        pulse(0, 0, 1, 0); model_coin(25);
        wait_water("t6b_water");
        repeat (3) @(negedge clk);
        #1 in_rst = 1'b1;
        #1 reset = 1'b0;
        #1;
        check("t6b_async_water", int'(water), 0);
        check("t6b_async_total", int'(total), 0);
        check("t6b_async_busy", int'(busy), 0);
        exp_total_q.delete();
        exp_change_q.delete();
        exp_disp_q.delete();
        exp_reject_q.delete();
        m_credit = 0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 in_rst = 1'b0;
        check("t6b_state_idle", int'(dut.state_r), int'(IDLE));
        pulse(0, 0, 1, 0); model_coin(25);
        repeat (3) @(negedge clk);
        pulse(0, 0, 0, 1); model_refund();
        wait_idle("t6b_idle");

        repeat (5) @(negedge clk);
        check("left_total", exp_total_q.size(), 0);
        check("left_change", exp_change_q.size(), 0);
        check("left_dispense", exp_disp_q.size(), 0);
        check("left_reject", exp_reject_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vend_sequencer.md
Name: vend_sequencer

Overview:
Central controller for the vending datapath. It takes the one-cycle coin pulses (A, B, C) and the stop pulse from the UART receivers and edge detectors, and arbitrates simultaneous coins. It also maintains the credit total shown on the 7-segment display, sequences the timed water dispense, and returns change or refunds. It replaces the free-running dispenser and sits between the edge detectors and the BCD/display path.

Parameters:
PRICE, 50, credit needed to start a dispense (units)
VAL_A, 5, credit value of coin A
VAL_B, 10, credit value of coin B
VAL_C, 25, credit value of coin C
DISP_TICKS, 3, dispense duration in tick pulses
IDLE_TIMEOUT, 10, tick pulses without an accepted coin in COLLECT before auto-refund
(Rule: PRICE-1+max(VAL_*) <= 127, so credit always fits 7 bits.)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset)
tick  in  1  one-cycle pulse, 1 Hz time base from the clock divider
coin_a  in  1  one-cycle pulse, coin A inserted
coin_b  in  1  one-cycle pulse, coin B inserted
coin_c  in  1  one-cycle pulse, coin C inserted
stop  in  1  one-cycle pulse, user cancel
total  out  7  current credit, unsigned binary, feeds binary_to_BCD
water  out  1  dispense valve, high for the whole dispense
change_due  out  7  change/refund amount, valid while change_valid=1
change_valid  out  1  one-cycle pulse, change/refund issued
reject  out  1  one-cycle pulse, a coin pulse was lost (pending overflow)
busy  out  1  high in DISPENSE and RETURN

Behaviour:
- Reset (async assert, sync-released use): state=IDLE; credit, pending bits, stop_pending and tick counter=0. All outputs are 0. water drops immediately on assert.
- Pending/arbitration:
  - Each coin type has a 1-deep pending bit.
  - pend_next = (pend & ~grant) | pulse.
  - If a pulse arrives while that bit is set and not granted this cycle, the pulse is lost and reject pulses on the next cycle.
  - At most one grant per cycle, fixed priority A > B > C.
  - Grants are issued only in IDLE or COLLECT. Pending coins are held through DISPENSE and RETURN.
- Latency: a pulse is sampled at edge k and the grant occurs at edge k+1. total reflects the added value after edge k+1 (2 cycles pulse-to-display when uncontested).
- stop: latched into stop_pending only in COLLECT, ignored elsewhere. Cleared on leaving COLLECT.
- FSM:
  - IDLE:
    - Grant: credit += value, then go to COLLECT; if the new credit >= PRICE, go to DISPENSE instead.
  - COLLECT:
    - Grant: add value and clear the tick counter; if new credit >= PRICE, go to DISPENSE.
    - Else if stop_pending and no coin pending: change_due=credit, go to RETURN.
    - Else if tick counter == IDLE_TIMEOUT: change_due=credit, go to RETURN.
    - The tick counter increments on tick.
    - Coins outrank stop, so a refund includes every coin latched before it.
  - DISPENSE:
    - On entry the tick counter is cleared; water=1.
    - Leave after DISPL_TICKS tick pulses have been counted.
    - If credit > PRICE: change_due = credit - PRICE, go to RETURN.
    - Otherwise credit=0 and go to IDLE.
  - RETURN:
    - change_valid=1 for exactly one cycle; credit=0; go to IDLE next cycle.
- total = credit register at all times.
- water is registered and asserted only in DISPENSE.

Decomposition:
- Package vend_pkg holds:
  - the state enum IDLE/COLLECT/DISPENSE/RETURN (2-bit);
  - the default coin values and PRICE;
  - the 7-bit credit width constant.
- Sub-module coin_arbiter holds the pending bits, priority grant, reject generation and granted-value mux. Its outputs are grant_valid, grant_value[6:0] and reject; its input is an enable (state is IDLE or COLLECT).

Test Plan:
1. coin_c, then coin_c 20 cycles later:
   - total goes 25, then 50.
   - The FSM enters DISPENSE; water is high for exactly 3 tick pulses.
   - No change_valid; back in IDLE with total=0.
2. coin_b, coin_c, coin_c:
   - total goes 10, 35, 60.
   - water is high for 3 ticks, then change_valid pulses once with change_due=10, then total=0.
3. coin_a, coin_b and coin_c in the same cycle while in IDLE:
   - total reads 5, 15, 40 on three consecutive cycles.
   - reject never asserts.
4. coin_c, then stop:
   - change_valid pulses with change_due=25, total becomes 0, water never asserts.
   - Variant: stop in the same cycle as a coin_a pulse gives a refund of 30.
5. During DISPENSE, two coin_c pulses 1 cycle apart:
   - reject pulses once.
   - After return to IDLE, total becomes 25 (one coin credited).
6. Timeout and reset:
   - coin_a, then 10 tick pulses with no coins: change_valid with change_due=5.
   - Separately, assert reset mid-DISPENSE: water and total go to 0 without waiting for a clk edge, and the FSM is in IDLE after release.
